// File: rtl/factorial_arbiter.sv
// Round-robin front end that time-shares one factorial engine among NUM_REQ
// requesters, with a watchdog that abandons jobs the engine never finishes.
module factorial_arbiter #(
  parameter int SIZE    = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*SIZE-1:0] req_n,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [SIZE-1:0]         rsp_result,
  output logic                    rsp_err,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    core_go,
  output logic [SIZE-1:0]         core_n,
  input  logic                    core_done,
  input  logic [SIZE-1:0]         core_result,
  output logic [2:0]              curr_state
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    BUSY    = 3'd2,
    DELIVER = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     win_q, win_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [SIZE-1:0]     core_n_q, core_n_d;
  logic [SIZE-1:0]     rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;
  logic                core_go_q, core_go_d;

  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic [WDW-1:0]      wd_inc;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan offsets from the largest down so the nearest set bit above ptr wins.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand[IDXW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDXW-1:0];
      end
    end
  end

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    wd_d         = wd_q;
    grant_d      = grant_q;
    core_n_d     = core_n_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = '0;
    core_go_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d     = pick_idx;
          grant_d   = onehot(pick_idx);
          core_n_d  = req_n[pick_idx*SIZE +: SIZE];
          core_go_d = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wd_d = wd_inc;
        // wd_q == 0 marks the first BUSY cycle, where done may still be stale.
        if (core_done && (wd_q != '0)) begin
          rsp_result_d = core_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = onehot(win_q);
          state_d      = DELIVER;
        end else if (wd_inc == WDW'(TIMEOUT)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = onehot(win_q);
          state_d      = DELIVER;
        end
      end
      DELIVER: begin
        ptr_d   = (win_q == IDXW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        grant_d = '0;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      wd_q         <= '0;
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      core_n_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      core_go_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      wd_q         <= wd_d;
      grant_q      <= grant_d;
      rsp_valid_q  <= rsp_valid_d;
      core_n_q     <= core_n_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      core_go_q    <= core_go_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign grant      = grant_q;
  assign core_go    = core_go_q;
  assign core_n     = core_n_q;
  assign curr_state = state_q;

endmodule
